video_sync_gen: RTL
===================

Name: video_sync_gen

Overview:
- Timing generator directly upstream of the bar/pattern cores. Produces pixel-tick-qualified horizontal/vertical counters hc/vc, hsync/vsync, video_on and frame-start pulse.
- Pattern generators decode hc/vc combinationally. The VGA output stage registers their RGB along with the sync signals.
- Default timing is 640x480@60 from a 50 MHz clk with divide-by-2 pixel tick.

Parameters:
- HSIZE, 11, width of hc
- VSIZE, 11, width of vc
- HDISPLAY, 640, visible pixels per line
- HFRONT, 16, horizontal front porch
- HSYNC, 96, horizontal sync width
- HBACK, 48, horizontal back porch
- VDISPLAY, 480, visible lines per frame
- VFRONT, 10, vertical front porch
- VSYNC, 2, vertical sync width
- VBACK, 33, vertical back porch
- CLK_DIV, 2, clk cycles per pixel (>=1)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- en  input  1  run enable; 0 = synchronous clear to frame origin
- pixel_tick  output  1  one-clk pulse, one per pixel period
- hc  output  HSIZE  horizontal count, 0..HTOTAL-1
- vc  output  VSIZE  vertical count, 0..VTOTAL-1
- hsync  output  1  horizontal sync, polarity per SYNC_POL
- vsync  output  1  vertical sync, polarity per SYNC_POL
- video_on  output  1  high when hc<HDISPLAY and vc<VDISPLAY
- frame_start  output  1  one-clk pulse coincident with pixel_tick at hc=0, vc=0

Behaviour:
- Fixed interface decision: one clock, clk; reset rst, asynchronous, active-high.
- Totals: HTOTAL=HDISPLAY+HFRONT+HSYNC+HBACK (800); VTOTAL=VDISPLAY+VFRONT+VSYNC+VBACK (525).
- Divider:
  - div counts 0..CLK_DIV-1 every clk while en=1.
  - pixel_tick=1 when div==CLK_DIV-1 (registered).
  - CLK_DIV=1 → pixel_tick constantly 1 while en=1.
- Counters advance only on the clk edge where pixel_tick=1.
  - hc wraps HTOTAL-1→0.
  - vc increments only when hc wraps; vc wraps VTOTAL-1→0 on the same edge that hc wraps.
- Outputs hsync, vsync, video_on are registered, decoded from the next-state counter values, so they are aligned with registered hc/vc in the same cycle. Latency from counter to decode is zero.
- hsync active iff HDISPLAY+HFRONT <= hc <= HDISPLAY+HFRONT+HSYNC-1 (656..751).
- vsync active iff VDISPLAY+VFRONT <= vc <= VDISPLAY+VFRONT+VSYNC-1 (490..491).
- frame_start=1 for the single clk where pixel_tick=1 and hc==0 and vc==0.
- Reset values:
  - div=0, hc=0, vc=0, pixel_tick=0, frame_start=0, video_on=0
  - hsync=vsync=inactive (~SYNC_POL)
- en=0:
  - Next edge forces div=0, hc=0, vc=0, pixel_tick=0, frame_start=0, video_on=0, syncs inactive.
  - State holds while en=0.
- en 0→1: first pixel_tick after CLK_DIV clks. At that tick, video_on becomes 1 at hc=0/vc=0 and frame_start pulses.
- Reset mid-frame: immediate return to reset values. There is no partial-frame completion.
- Counters never exceed HTOTAL-1/VTOTAL-1. Parameter sanity: HTOTAL < 2**HSIZE, VTOTAL < 2**VSIZE (elaboration assertion).

Optional Feature:
- Macro: VIDEO_SYNC_FRAME_CNT_EN.
- Defined: adds output frame_cnt [7:0].
  - Increments (wrap 255→0) on each frame_start.
  - Reset and en=0 clear it to 0.
  - The first frame after reset reads 1 one clk after its frame_start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Defaults, release rst, en=1 → pixel_tick every 2nd clk; hc 0..799 then 0; vc increments at hc wrap; 800*525*2=840000 clks between frame_start pulses.
- Line decode → hsync low exactly for hc 656..751 (96 ticks); video_on high for hc 0..639 on lines vc 0..479, low for all of vc 480..524.
- Frame decode → vsync low exactly for vc 490..491; at hc=799, vc=524 the next tick gives hc=0, vc=0 with frame_start=1.
- SYNC_POL=1, CLK_DIV=1 → syncs active-high at the same counts; pixel_tick constantly 1; frame period 420000 clks.
- Assert rst asynchronously at hc=300, vc=200 (between edges), and separately drop en for 10 clks → outputs at reset values immediately or next edge respectively; restart gives frame_start on first tick.
- With VIDEO_SYNC_FRAME_CNT_EN, run 257 frames → frame_cnt sequence 1..255, 0, 1; en=0 → frame_cnt=0.

Source files
------------

// File: rtl/video_sync_gen.sv
// Raster timing generator: pixel-tick divider, hc/vc counters, hsync/vsync, video_on, frame_start.
// Optional macro VIDEO_SYNC_FRAME_CNT_EN adds an 8-bit frame counter output frame_cnt.
module video_sync_gen #(
  parameter int HSIZE    = 11,
  parameter int VSIZE    = 11,
  parameter int HDISPLAY = 640,
  parameter int HFRONT   = 16,
  parameter int HSYNC    = 96,
  parameter int HBACK    = 48,
  parameter int VDISPLAY = 480,
  parameter int VFRONT   = 10,
  parameter int VSYNC    = 2,
  parameter int VBACK    = 33,
  parameter int CLK_DIV  = 2,
  parameter int SYNC_POL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             pixel_tick,
  output logic [HSIZE-1:0] hc,
  output logic [VSIZE-1:0] vc,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             frame_start
`ifdef VIDEO_SYNC_FRAME_CNT_EN
  ,
  output logic [7:0]       frame_cnt
`endif
);

  localparam int HTOTAL   = HDISPLAY + HFRONT + HSYNC + HBACK;
  localparam int VTOTAL   = VDISPLAY + VFRONT + VSYNC + VBACK;
  localparam int HS_FIRST = HDISPLAY + HFRONT;
  localparam int VS_FIRST = VDISPLAY + VFRONT;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [HSIZE-1:0] H_LAST   = HSIZE'(HTOTAL - 1);
  localparam logic [HSIZE-1:0] H_DISP   = HSIZE'(HDISPLAY);
  localparam logic [HSIZE-1:0] HS_LO    = HSIZE'(HS_FIRST);
  localparam logic [HSIZE-1:0] HS_HI    = HSIZE'(HS_FIRST + HSYNC - 1);
  localparam logic [VSIZE-1:0] V_LAST   = VSIZE'(VTOTAL - 1);
  localparam logic [VSIZE-1:0] V_DISP   = VSIZE'(VDISPLAY);
  localparam logic [VSIZE-1:0] VS_LO    = VSIZE'(VS_FIRST);
  localparam logic [VSIZE-1:0] VS_HI    = VSIZE'(VS_FIRST + VSYNC - 1);
  localparam logic             SYNC_ACT = (SYNC_POL != 0);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("video_sync_gen: CLK_DIV must be >= 1");
  end
  if (HTOTAL >= (1 << HSIZE)) begin : g_bad_hsize
    $error("video_sync_gen: HTOTAL does not fit in HSIZE bits");
  end
  if (VTOTAL >= (1 << VSIZE)) begin : g_bad_vsize
    $error("video_sync_gen: VTOTAL does not fit in VSIZE bits");
  end

  logic [DIV_W-1:0] div, div_nxt;
  logic [HSIZE-1:0] hc_nxt;
  logic [VSIZE-1:0] vc_nxt;
  logic             tick_nxt;
  logic             run_q, run_nxt;
  logic             h_sync_win, v_sync_win, disp_win;

  // run_q marks that the first pixel tick since enable has been issued;
  // video_on stays low until then so it rises together with that tick.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    div_nxt  = '0;
    hc_nxt   = '0;
    vc_nxt   = '0;
    run_nxt  = 1'b0;
    tick_nxt = en && (div == DIV_LAST);
    if (en) begin
      div_nxt = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
      hc_nxt  = hc;
      vc_nxt  = vc;
      if (pixel_tick) begin
        if (hc == H_LAST) begin
          hc_nxt = '0;
          vc_nxt = (vc == V_LAST) ? '0 : vc + VSIZE'(1);
        end else begin
          hc_nxt = hc + HSIZE'(1);
        end
      end
      run_nxt = run_q || tick_nxt;
    end
  end

  always_comb begin
    h_sync_win = (hc_nxt >= HS_LO) && (hc_nxt <= HS_HI);
    v_sync_win = (vc_nxt >= VS_LO) && (vc_nxt <= VS_HI);
    disp_win   = (hc_nxt < H_DISP) && (vc_nxt < V_DISP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div         <= '0;
      pixel_tick  <= 1'b0;
      hc          <= '0;
      vc          <= '0;
      run_q       <= 1'b0;
      video_on    <= 1'b0;
      hsync       <= ~SYNC_ACT;
      vsync       <= ~SYNC_ACT;
      frame_start <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge values of the others.
      div         <= div_nxt;
      pixel_tick  <= tick_nxt;
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      run_q       <= run_nxt;
      video_on    <= run_nxt && disp_win;
      hsync       <= (run_nxt && h_sync_win) ? SYNC_ACT : ~SYNC_ACT;
      vsync       <= (run_nxt && v_sync_win) ? SYNC_ACT : ~SYNC_ACT;
      frame_start <= tick_nxt && (hc_nxt == '0) && (vc_nxt == '0);
    end
  end

`ifdef VIDEO_SYNC_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (!en) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule
